// File: rtl/lib_arbiter_pkg.sv
// Shared types, derived constants and the rotate-priority search for the pixel grouping arbiter.
// The search works on a fixed MAX_PIX-wide vector, so groups are limited to 8x8 pixels.
package lib_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } grp_state_e;

  localparam int MAX_PIX = 64;
  localparam int IDX_W   = 6;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int calc_aw(input int rows, input int cols, input int grp, input int glob);
    return (glob != 0) ? clog2_min1((rows > cols) ? rows : cols) : clog2_min1(grp);
  endfunction

  localparam int DEF_ROWS     = 8;
  localparam int DEF_COLS     = 8;
  localparam int DEF_GRP_SIZE = 2;
  localparam int GRP_ROWS     = DEF_ROWS / DEF_GRP_SIZE;
  localparam int GRP_COLS     = DEF_COLS / DEF_GRP_SIZE;
  localparam int NUM_GRPS     = GRP_ROWS * GRP_COLS;
  localparam int GRP_PIX      = DEF_GRP_SIZE * DEF_GRP_SIZE;
  localparam int AW           = calc_aw(DEF_ROWS, DEF_COLS, DEF_GRP_SIZE, 0);

  // First set bit of vec[0..n-1] at or after ptr, wrapping; ptr must be below n.
  function automatic rr_pick_t rr_first(input logic [MAX_PIX-1:0] vec, input int ptr, input int n);
    rr_pick_t pick;
    int idx;
    pick = '0;
    idx  = 0;
    // Scan from the far end so the closest candidate to ptr is written last.
    for (int k = MAX_PIX - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (ptr + k >= n) ? (ptr + k - n) : (ptr + k);
        if (vec[IDX_W'(idx)]) begin
          pick.found = 1'b1;
          pick.idx   = IDX_W'(idx);
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pixel_group_rr_fsm.sv
// One pixel group: snapshots its requests on enable, serves them round-robin, pulses release when empty.
// First event one cycle after capture; selection and polarity hold while ready is low or enable drops.
module pixel_group_rr_fsm
  import lib_arbiter_pkg::*;
#(
  parameter int GRP_SIZE = DEF_GRP_SIZE,
  parameter int POLARITY = 2,
  localparam int NPIX    = GRP_SIZE * GRP_SIZE,
  localparam int LW      = clog2_min1(NPIX)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NPIX-1:0][POLARITY-1:0] req_i,
  input  logic                          enable_i,
  input  logic                          evt_ready_i,
  output logic                          req_o,
  output logic                          evt_valid_o,
  output logic [LW-1:0]                 sel_o,
  output logic [POLARITY-1:0]           pol_o,
  output logic                          release_o,
  output logic                          active_o
);

  grp_state_e                    state_q, state_d;
  logic [NPIX-1:0][POLARITY-1:0] snap_q, snap_d;
  logic [LW-1:0]                 ptr_q, ptr_d;
  logic [LW-1:0]                 sel;
  logic [NPIX-1:0]               live, pend, rest;
  rr_pick_t                      pick;

  for (genvar p = 0; p < NPIX; p++) begin : g_or
    assign live[p] = |req_i[p];
    assign pend[p] = |snap_q[p];
  end

  assign pick = rr_first(MAX_PIX'(pend), int'(ptr_q), NPIX);
  assign sel  = LW'(pick.idx);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      snap_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    ptr_d       = ptr_q;
    rest        = pend;
    req_o       = 1'b0;
    evt_valid_o = 1'b0;
    release_o   = 1'b0;
    case (state_q)
      IDLE: begin
        req_o = |live;
        if (enable_i && (|live)) begin
          snap_d  = req_i;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Requests arriving now wait for the next round; req_o stays up meanwhile.
        req_o = 1'b1;
        if (enable_i && pick.found) begin
          evt_valid_o = 1'b1;
          if (evt_ready_i) begin
            snap_d[sel] = '0;
            rest[sel]   = 1'b0;
            ptr_d       = (sel == LW'(NPIX - 1)) ? '0 : sel + 1'b1;
            if (rest == '0) state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        release_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_o    = sel;
  assign pol_o    = snap_q[sel];
  assign active_o = (state_q == GRANT);

endmodule

// File: rtl/pixel_groups_rr_level.sv
// Tiles the array into groups, muxes the lowest-indexed enabled group onto the event outputs.
// One event per cycle; only the muxed group sees evt_ready_i, so other enabled groups stall.
module pixel_groups_rr_level
  import lib_arbiter_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int COLS        = DEF_COLS,
  parameter int POLARITY    = 2,
  parameter int GRP_SIZE    = DEF_GRP_SIZE,
  parameter int GLOBAL_ADDR = 0,
  localparam int GRPS_R     = ROWS / GRP_SIZE,
  localparam int GRPS_C     = COLS / GRP_SIZE,
  localparam int ADDR_W     = calc_aw(ROWS, COLS, GRP_SIZE, GLOBAL_ADDR)
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [ROWS-1:0][COLS-1:0][POLARITY-1:0]  req_i,
  input  logic [GRPS_R-1:0][GRPS_C-1:0]            enable_i,
  output logic [GRPS_R-1:0][GRPS_C-1:0]            req_o,
  output logic [ROWS-1:0][COLS-1:0]                gnt_out_o,
  output logic                                     evt_valid_o,
  input  logic                                     evt_ready_i,
  output logic [ADDR_W-1:0]                        x_add_o,
  output logic [ADDR_W-1:0]                        y_add_o,
  output logic [POLARITY-1:0]                      pol_o,
  output logic                                     active_o,
  output logic                                     grp_release_o
);

  localparam int N_GRP       = GRPS_R * GRPS_C;
  localparam int PIX_PER_GRP = GRP_SIZE * GRP_SIZE;
  localparam int LW          = clog2_min1(PIX_PER_GRP);
  localparam int GW          = clog2_min1(N_GRP);
  localparam int GNT_W       = clog2_min1(ROWS * COLS);

  logic [N_GRP-1:0]       en_flat, grp_rdy, g_req, g_vld, g_rel, g_act;
  logic [LW-1:0]          g_sel [N_GRP];
  logic [POLARITY-1:0]    g_pol [N_GRP];
  logic [GW-1:0]          sel_grp;
  logic                   any_en;
  logic [ROWS*COLS-1:0]   gnt_flat;
  int                     gr, gc, lr, lc;

  assign en_flat = enable_i;

  for (genvar r = 0; r < GRPS_R; r++) begin : g_row
    for (genvar c = 0; c < GRPS_C; c++) begin : g_col
      logic [PIX_PER_GRP-1:0][POLARITY-1:0] grp_req;
      for (genvar pr = 0; pr < GRP_SIZE; pr++) begin : g_pr
        for (genvar pc = 0; pc < GRP_SIZE; pc++) begin : g_pc
          assign grp_req[pr*GRP_SIZE+pc] = req_i[r*GRP_SIZE+pr][c*GRP_SIZE+pc];
        end
      end
      pixel_group_rr_fsm #(
        .GRP_SIZE (GRP_SIZE),
        .POLARITY (POLARITY)
      ) u_fsm (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_i       (grp_req),
        .enable_i    (enable_i[r][c]),
        .evt_ready_i (grp_rdy[r*GRPS_C+c]),
        .req_o       (g_req[r*GRPS_C+c]),
        .evt_valid_o (g_vld[r*GRPS_C+c]),
        .sel_o       (g_sel[r*GRPS_C+c]),
        .pol_o       (g_pol[r*GRPS_C+c]),
        .release_o   (g_rel[r*GRPS_C+c]),
        .active_o    (g_act[r*GRPS_C+c])
      );
    end
  end

  // Only one enable should be high; if not, the lowest raster index wins.
  always_comb begin
    sel_grp = '0;
    any_en  = |en_flat;
    for (int g = N_GRP - 1; g >= 0; g--) begin
      if (en_flat[g]) sel_grp = GW'(g);
    end
  end

  always_comb begin
    grp_rdy = '0;
    if (any_en) grp_rdy[sel_grp] = evt_ready_i;
  end

  // Group FSM req in IDLE follows live inputs; hold it low while reset is asserted.
  assign req_o    = g_req & {N_GRP{reset_i}};
  assign active_o = |g_act;

  always_comb begin
    evt_valid_o   = 1'b0;
    grp_release_o = 1'b0;
    pol_o         = '0;
    x_add_o       = '0;
    y_add_o       = '0;
    gnt_flat      = '0;
    gr            = 0;
    gc            = 0;
    lr            = 0;
    lc            = 0;
    if (any_en) begin
      gr            = int'(sel_grp) / GRPS_C;
      gc            = int'(sel_grp) % GRPS_C;
      lr            = int'(g_sel[sel_grp]) / GRP_SIZE;
      lc            = int'(g_sel[sel_grp]) % GRP_SIZE;
      grp_release_o = g_rel[sel_grp];
      if (g_vld[sel_grp]) begin
        evt_valid_o = 1'b1;
        pol_o       = g_pol[sel_grp];
        gnt_flat[GNT_W'((gr*GRP_SIZE + lr) * COLS + gc*GRP_SIZE + lc)] = 1'b1;
        if (GLOBAL_ADDR != 0) begin
          x_add_o = ADDR_W'(gr*GRP_SIZE + lr);
          y_add_o = ADDR_W'(gc*GRP_SIZE + lc);
        end else begin
          x_add_o = ADDR_W'(lr);
          y_add_o = ADDR_W'(lc);
        end
      end
    end
  end

  assign gnt_out_o = gnt_flat;

endmodule
